// File: rtl/product_bcd_converter.sv
// Sequential double-dabble binary-to-packed-BCD converter with valid/ready handshake.
// Optional 7-segment decode of the result when PRODUCT_BCD_SEG_EN is defined.

module product_bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

module product_bcd_seg7 (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h40;
    case (bcd)
      4'd0: seg = 7'h3F;
      4'd1: seg = 7'h06;
      4'd2: seg = 7'h5B;
      4'd3: seg = 7'h4F;
      4'd4: seg = 7'h66;
      4'd5: seg = 7'h6D;
      4'd6: seg = 7'h7D;
      4'd7: seg = 7'h07;
      4'd8: seg = 7'h7F;
      4'd9: seg = 7'h6F;
      default: seg = 7'h40;
    endcase
  end
endmodule

module product_bcd_converter #(
  parameter int p_data_width = 14,
  parameter int p_digits     = 5
) (
  input  logic                      i_w_clk,
  input  logic                      i_w_reset,
  input  logic [p_data_width-1:0]   i_w_data,
  input  logic                      i_w_valid,
  output logic                      o_w_ready,
  output logic [4*p_digits-1:0]     o_w_bcd,
  output logic                      o_w_valid,
`ifdef PRODUCT_BCD_SEG_EN
  output logic [7*p_digits-1:0]     o_w_seg,
`endif
  output logic                      o_w_overflow
);
  localparam int W  = p_data_width;
  localparam int D  = p_digits;
  localparam int CW = $clog2(W + 1);
  localparam logic [63:0] MAX_VAL = 64'(10**D) - 64'd1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nxt;

  logic [W-1:0]        shreg;
  logic [D-1:0][3:0]   scratch, corr;
  logic [4*D-1:0]      corr_flat, scratch_shl;
  logic [CW-1:0]       cnt;
  logic                ovf;
  logic                accept, last_shift;

  // Per-digit +3 correction; carries out of the top digit fall off, giving mod 10**D.
  genvar g;
  generate
    for (g = 0; g < D; g++) begin : g_dig
      product_bcd_add3 u_add3 (.din(scratch[g]), .dout(corr[g]));
    end
  endgenerate

  assign corr_flat   = corr;
  assign scratch_shl = {corr_flat[4*D-2:0], shreg[W-1]};
  assign accept      = (state == IDLE) && i_w_valid;
  assign last_shift  = (state == SHIFT) && (cnt == CW'(1));

  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_w_valid) state_nxt = SHIFT;
      SHIFT:   if (last_shift) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_w_ready = (state == IDLE);
    o_w_valid = (state == DONE);
  end

  // Result registers only load on the final shift, so intermediate scratch never shows.
  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) begin
      shreg        <= '0;
      scratch      <= '0;
      cnt          <= '0;
      ovf          <= 1'b0;
      o_w_bcd      <= '0;
      o_w_overflow <= 1'b0;
    end else if (accept) begin
      shreg   <= i_w_data;
      scratch <= '0;
      cnt     <= CW'(W);
      ovf     <= 64'(i_w_data) > MAX_VAL;
    end else if (state == SHIFT) begin
      shreg   <= {shreg[W-2:0], 1'b0};
      scratch <= scratch_shl;
      cnt     <= cnt - CW'(1);
      if (last_shift) begin
        o_w_bcd      <= scratch_shl;
        o_w_overflow <= ovf;
      end
    end
  end

`ifdef PRODUCT_BCD_SEG_EN
  generate
    for (g = 0; g < D; g++) begin : g_seg
      product_bcd_seg7 u_seg (.bcd(o_w_bcd[4*g +: 4]), .seg(o_w_seg[7*g +: 7]));
    end
  endgenerate
`endif

endmodule

// File: tb/tb_product_bcd_converter.sv
// Randomized self-checking bench for product_bcd_converter (5-digit and 4-digit instances).
// Reference results are computed with integer div/mod on the input value.

module tb_product_bcd_converter;
  logic        clk = 1'b0;
  logic        rst, valid, valid4;
  logic [13:0] data;
  logic        rdy5, vld5, ovf5, rdy4, vld4, ovf4;
  logic [19:0] bcd5;
  logic [15:0] bcd4;
`ifdef PRODUCT_BCD_SEG_EN
  logic [34:0] seg5;
  logic [27:0] seg4;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  product_bcd_converter #(.p_data_width(14), .p_digits(5)) dut (
    .i_w_clk(clk), .i_w_reset(rst), .i_w_data(data), .i_w_valid(valid),
    .o_w_ready(rdy5), .o_w_bcd(bcd5), .o_w_valid(vld5),
`ifdef PRODUCT_BCD_SEG_EN
    .o_w_seg(seg5),
`endif
    .o_w_overflow(ovf5));

  product_bcd_converter #(.p_data_width(14), .p_digits(4)) dut4 (
    .i_w_clk(clk), .i_w_reset(rst), .i_w_data(data), .i_w_valid(valid4),
    .o_w_ready(rdy4), .o_w_bcd(bcd4), .o_w_valid(vld4),
`ifdef PRODUCT_BCD_SEG_EN
    .o_w_seg(seg4),
`endif
    .o_w_overflow(ovf4));

  function automatic logic [19:0] ref_bcd(input int v, input int nd);
    logic [19:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Drive one request into the selected instance, return latency from accept edge to pulse.
  task automatic run_conv(input int sel, input logic [13:0] d, output int lat,
                          output logic [19:0] bcd, output logic ovf);
    @(negedge clk);
    data = d;
    if (sel == 4) valid4 = 1'b1; else valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    valid4 = 1'b0;
    lat = 0;
    while (!((sel == 4) ? vld4 : vld5) && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    bcd = (sel == 4) ? {4'h0, bcd4} : bcd5;
    ovf = (sel == 4) ? ovf4 : ovf5;
  endtask

  task automatic test_reset();
    checks++; if (rdy5 !== 1'b1) begin errors++; $display("FAIL reset_ready5 got=%b exp=1", rdy5); end
    checks++; if (vld5 !== 1'b0) begin errors++; $display("FAIL reset_valid5 got=%b exp=0", vld5); end
    checks++; if (bcd5 !== 20'h0) begin errors++; $display("FAIL reset_bcd5 got=%h exp=0", bcd5); end
    checks++; if (ovf5 !== 1'b0) begin errors++; $display("FAIL reset_ovf5 got=%b exp=0", ovf5); end
    checks++; if (rdy4 !== 1'b1 || vld4 !== 1'b0 || bcd4 !== 16'h0 || ovf4 !== 1'b0) begin
      errors++; $display("FAIL reset_dut4 got=%b%b%h%b exp=1,0,0000,0", rdy4, vld4, bcd4, ovf4);
    end
`ifdef PRODUCT_BCD_SEG_EN
    checks++; if (seg5 !== {5{7'h3F}}) begin errors++; $display("FAIL reset_seg got=%h exp=%h", seg5, {5{7'h3F}}); end
`endif
  endtask

  task automatic test_zero();
    int lat; logic [19:0] b; logic o;
    run_conv(5, 14'd0, lat, b, o);
    checks++; if (lat !== 14) begin errors++; $display("FAIL zero_latency got=%0d exp=14", lat); end
    checks++; if (b !== 20'h0) begin errors++; $display("FAIL zero_bcd got=%h exp=0", b); end
    checks++; if (o !== 1'b0) begin errors++; $display("FAIL zero_ovf got=%b exp=0", o); end
  endtask

  task automatic test_product();
    int n; logic [19:0] b; logic seen;
    @(negedge clk);
    data = 14'd16129; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    n = 0; seen = 1'b0; b = '0;
    while (!rdy5 && n < 100) begin
      if (vld5) begin seen = 1'b1; b = bcd5; end
      n++;
      @(negedge clk);
    end
    checks++; if (n !== 15) begin errors++; $display("FAIL product_ready_low got=%0d exp=15", n); end
    checks++; if (!seen || b !== 20'h16129) begin errors++; $display("FAIL product_bcd got=%h seen=%b exp=16129", b, seen); end
    checks++; if (ovf5 !== 1'b0) begin errors++; $display("FAIL product_ovf got=%b exp=0", ovf5); end
  endtask

  // Valid held high; data is junk while busy and 16383 whenever ready is visible.
  task automatic test_back_to_back();
    int pulses, t, first_t, second_t;
    pulses = 0; first_t = 0; second_t = 0;
    @(negedge clk);
    for (t = 0; t < 80; t++) begin
      if (vld5) begin
        pulses++;
        if (pulses == 1) first_t = t; else second_t = t;
        checks++; if (bcd5 !== 20'h16383) begin errors++; $display("FAIL b2b_bcd got=%h exp=16383", bcd5); end
        if (pulses == 2) break;
      end else if (pulses == 1) begin
        checks++; if (bcd5 !== 20'h16383) begin errors++; $display("FAIL b2b_stable got=%h exp=16383", bcd5); end
      end
      valid = 1'b1;
      data = rdy5 ? 14'd16383 : 14'($urandom);
      @(negedge clk);
    end
    valid = 1'b0;
    checks++; if (pulses !== 2 || second_t - first_t !== 16) begin
      errors++; $display("FAIL b2b_period got=%0d pulses=%0d exp=16", second_t - first_t, pulses);
    end
    @(negedge clk);
  endtask

  task automatic test_overflow4();
    int lat; logic [19:0] b; logic o;
    run_conv(4, 14'd16383, lat, b, o);
    checks++; if (b[15:0] !== 16'h6383 || o !== 1'b1) begin errors++; $display("FAIL ovf4_16383 got=%h/%b exp=6383/1", b[15:0], o); end
    run_conv(4, 14'd9999, lat, b, o);
    checks++; if (b[15:0] !== 16'h9999 || o !== 1'b0) begin errors++; $display("FAIL ovf4_9999 got=%h/%b exp=9999/0", b[15:0], o); end
    run_conv(4, 14'd10000, lat, b, o);
    checks++; if (b[15:0] !== 16'h0000 || o !== 1'b1) begin errors++; $display("FAIL ovf4_10000 got=%h/%b exp=0000/1", b[15:0], o); end
  endtask

  task automatic test_random();
    int lat, v; logic [19:0] b, e; logic o;
    for (int k = 0; k < 12; k++) begin
      v = int'($urandom_range(16383, 0));
      run_conv(5, 14'(v), lat, b, o);
      e = ref_bcd(v, 5);
      checks++; if (b !== e || o !== 1'b0 || lat !== 14) begin
        errors++; $display("FAIL rand5 in=%0d got=%h/%b/%0d exp=%h/0/14", v, b, o, lat, e);
      end
      v = int'($urandom_range(16383, 0));
      run_conv(4, 14'(v), lat, b, o);
      e = ref_bcd(v % 10000, 4);
      checks++; if (b[15:0] !== e[15:0] || o !== (v > 9999) || lat !== 14) begin
        errors++; $display("FAIL rand4 in=%0d got=%h/%b/%0d exp=%h/%b/14", v, b[15:0], o, lat, e[15:0], v > 9999);
      end
    end
  endtask

  task automatic test_abort();
    int lat; logic [19:0] b; logic o, seen;
    @(negedge clk);
    data = 14'd12345; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (rdy5 !== 1'b1 || vld5 !== 1'b0 || bcd5 !== 20'h0 || ovf5 !== 1'b0) begin
      errors++; $display("FAIL abort_reset got=%b%b%h%b exp=1,0,00000,0", rdy5, vld5, bcd5, ovf5);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (vld5) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0 || bcd5 !== 20'h0) begin errors++; $display("FAIL abort_nopulse got=%b/%h exp=0/00000", seen, bcd5); end
    run_conv(5, 14'd12345, lat, b, o);
    checks++; if (b !== 20'h12345 || lat !== 14) begin errors++; $display("FAIL abort_retry got=%h/%0d exp=12345/14", b, lat); end
  endtask

`ifdef PRODUCT_BCD_SEG_EN
  task automatic test_seg();
    int lat, v; logic [19:0] b, e; logic o;
    logic [6:0] glyph [10];
    logic [34:0] es;
    glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    run_conv(5, 14'd8090, lat, b, o);
    checks++; if (seg5 !== {7'h3F, 7'h7F, 7'h3F, 7'h6F, 7'h3F}) begin
      errors++; $display("FAIL seg_8090 got=%h exp=%h", seg5, {7'h3F, 7'h7F, 7'h3F, 7'h6F, 7'h3F});
    end
    for (int k = 0; k < 4; k++) begin
      v = int'($urandom_range(16383, 0));
      run_conv(5, 14'(v), lat, b, o);
      es = '0;
      for (int i = 0, x = v; i < 5; i++, x = x / 10) es[7*i +: 7] = glyph[x % 10];
      checks++; if (seg5 !== es) begin errors++; $display("FAIL seg_rand in=%0d got=%h exp=%h", v, seg5, es); end
    end
  endtask
`endif

  initial begin
    rst = 1'b1; valid = 1'b0; valid4 = 1'b0; data = '0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_zero();
    test_product();
    test_back_to_back();
    test_overflow4();
    test_random();
    test_abort();
`ifdef PRODUCT_BCD_SEG_EN
    test_seg();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
